// File: rtl/bluetooth_resp_tx.sv
// Bluetooth response framer: queues ACK/ERR/position replies and feeds them
// byte by byte to the UART TX core through a start/busy handshake.
module bluetooth_resp_tx #(
  parameter int unsigned BUSY_WAIT_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ack_req,
  input  logic       err_req,
  input  logic       pos_req,
  input  logic [1:0] pos_x,
  input  logic [1:0] pos_y,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       resp_busy
);

  localparam int unsigned CW = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_HI, S_WAIT_LO} state_t;
  typedef enum logic [1:0] {F_ERR, F_ACK, F_POS} frame_t;

  state_t        r_state, w_state_nxt;
  frame_t        r_frame;
  logic          r_pend_err, r_pend_ack, r_pend_pos;
  logic [1:0]    r_pos_x, r_pos_y;
  logic [1:0]    r_snap_x, r_snap_y;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tx_data;

  logic          w_sel_err, w_sel_ack, w_sel_pos;
  logic          w_start, w_adv, w_last;
  logic [7:0]    w_byte;

  // Byte at the current index of the frame being sent.
  always_comb begin
    w_byte = '0;
    unique case (r_frame)
      F_ERR, F_ACK: begin
        unique case (r_idx)
          3'd0:    w_byte = (r_frame == F_ERR) ? 8'h45 : 8'h4F;
          3'd1:    w_byte = (r_frame == F_ERR) ? 8'h52 : 8'h4B;
          3'd2:    w_byte = 8'h0D;
          default: w_byte = 8'h0A;
        endcase
      end
      default: begin
        unique case (r_idx)
          3'd0:    w_byte = 8'h28;
          3'd1:    w_byte = 8'h30 | {6'b0, r_snap_x};
          3'd2:    w_byte = 8'h2C;
          3'd3:    w_byte = 8'h30 | {6'b0, r_snap_y};
          3'd4:    w_byte = 8'h29;
          3'd5:    w_byte = 8'h0D;
          default: w_byte = 8'h0A;
        endcase
      end
    endcase
  end

  assign w_last = (r_frame == F_POS) ? (r_idx == 3'd6) : (r_idx == 3'd3);

  // Next-state, frame selection and handshake strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_err   = 1'b0;
    w_sel_ack   = 1'b0;
    w_sel_pos   = 1'b0;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend_err || r_pend_ack || r_pend_pos) begin
          w_state_nxt = S_LOAD;
          if (r_pend_err)      w_sel_err = 1'b1;
          else if (r_pend_ack) w_sel_ack = 1'b1;
          else                 w_sel_pos = 1'b1;
        end
      end
      S_LOAD: begin
        if (!tx_busy) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy || (r_cnt == CW'(BUSY_WAIT_MAX - 1)))
          w_state_nxt = S_WAIT_LO;
      end
      default: begin
        if (!tx_busy) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOAD;
            w_adv       = 1'b1;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture: a new pulse in the select cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_err <= 1'b0;
      r_pend_ack <= 1'b0;
      r_pend_pos <= 1'b0;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
    end else begin
      r_pend_err <= (r_pend_err & ~w_sel_err) | err_req;
      r_pend_ack <= (r_pend_ack & ~w_sel_ack) | ack_req;
      r_pend_pos <= (r_pend_pos & ~w_sel_pos) | pos_req;
      if (pos_req) begin
        r_pos_x <= pos_x;
        r_pos_y <= pos_y;
      end
    end
  end

  // Frame context: type, coordinate snapshot and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame  <= F_ERR;
      r_snap_x <= '0;
      r_snap_y <= '0;
      r_idx    <= '0;
    end else if (w_sel_err || w_sel_ack || w_sel_pos) begin
      r_frame  <= w_sel_err ? F_ERR : (w_sel_ack ? F_ACK : F_POS);
      r_snap_x <= r_pos_x;
      r_snap_y <= r_pos_y;
      r_idx    <= '0;
    end else if (w_adv) begin
      r_idx    <= r_idx + 3'd1;
    end
  end

  // Busy-rise timeout counter, running only while waiting in WAIT_HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (r_state == S_WAIT_HI) r_cnt <= r_cnt + 1'b1;
    else                          r_cnt <= '0;
  end

  // Last transmitted byte, held between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_tx_data <= '0;
    else if (w_start) r_tx_data <= w_byte;
  end

  // tx_data switches to the new byte in the same cycle as tx_start.
  assign tx_start  = w_start;
  assign tx_data   = w_start ? w_byte : r_tx_data;
  assign resp_busy = (r_state != S_IDLE) || r_pend_err || r_pend_ack || r_pend_pos;

endmodule

// File: tb/tb_bluetooth_resp_tx.sv
// Directed bench for bluetooth_resp_tx with a simple UART busy model.
module tb_bluetooth_resp_tx;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ack_req, err_req, pos_req;
  logic [1:0] pos_x, pos_y;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       resp_busy;

  logic       uart_stuck;
  logic [3:0] busy_cnt;
  int unsigned cyc;
  int unsigned viol;
  int unsigned n_chk, n_pass;
  byte_q_t     cap;
  int unsigned stamps[$];

  bluetooth_resp_tx #(.BUSY_WAIT_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ack_req   (ack_req),
    .err_req   (err_req),
    .pos_req   (pos_req),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .resp_busy (resp_busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles starting right after the accepting edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start && rst_n && !uart_stuck) busy_cnt <= 4'd10;
    else if (busy_cnt != 0)               busy_cnt <= busy_cnt - 4'd1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Byte capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      cap.push_back(tx_data);
      stamps.push_back(cyc);
      if (tx_busy) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic pulse(input logic a, input logic e, input logic p,
                       input logic [1:0] x, input logic [1:0] y);
    @(negedge clk);
    ack_req = a; err_req = e; pos_req = p; pos_x = x; pos_y = y;
    @(negedge clk);
    ack_req = 1'b0; err_req = 1'b0; pos_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (resp_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'b0, resp_busy}, 32'd0);
  endtask

  task automatic chk_frame(input string tag, input byte_q_t e);
    check({tag, "_count"}, cap.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < cap.size()) check($sformatf("%s_b%0d", tag, i), {24'b0, cap[i]}, {24'b0, e[i]});
    check({tag, "_nobusy"}, viol, 32'd0);
  endtask

  task automatic clear_cap();
    cap.delete();
    stamps.delete();
    viol = 0;
  endtask

  initial begin
    byte_q_t e;
    int unsigned n;
    rst_n = 1'b0; ack_req = 1'b0; err_req = 1'b0; pos_req = 1'b0;
    pos_x = '0; pos_y = '0; uart_stuck = 1'b0; busy_cnt = '0; cyc = 0;
    viol = 0; n_chk = 0; n_pass = 0;
    repeat (3) @(negedge clk);
    check("rst_start", {31'b0, tx_start}, 32'd0);
    check("rst_data", {24'b0, tx_data}, 32'd0);
    check("rst_busy", {31'b0, resp_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ACK frame with latency check
    clear_cap();
    pulse(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    check("ack_rbusy_c1", {31'b0, resp_busy}, 32'd1);
    check("ack_nostart_c1", {31'b0, tx_start}, 32'd0);
    @(negedge clk);
    check("ack_start_c2", {31'b0, tx_start}, 32'd1);
    check("ack_data_c2", {24'b0, tx_data}, 32'h4F);
    wait_idle("ack", 200);
    e = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    chk_frame("ack", e);
    check("ack_hold", {24'b0, tx_data}, 32'h0A);

    // POS frame (2,3)
    clear_cap();
    pulse(1'b0, 1'b0, 1'b1, 2'd2, 2'd3);
    wait_idle("pos23", 300);
    e = '{8'h28, 8'h32, 8'h2C, 8'h33, 8'h29, 8'h0D, 8'h0A};
    chk_frame("pos23", e);

    // Simultaneous requests: ERR, ACK, then POS (1,0)
    clear_cap();
    pulse(1'b1, 1'b1, 1'b1, 2'd1, 2'd0);
    wait_idle("all3", 600);
    e = '{8'h45, 8'h52, 8'h0D, 8'h0A, 8'h4F, 8'h4B, 8'h0D, 8'h0A,
          8'h28, 8'h31, 8'h2C, 8'h30, 8'h29, 8'h0D, 8'h0A};
    chk_frame("all3", e);

    // Two position updates during an OK frame merge; newest wins
    clear_cap();
    pulse(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    repeat (4) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    repeat (10) @(negedge clk);
    pulse(1'b0, 1'b0, 1'b1, 2'd3, 2'd1);
    check("merge_midframe", {31'b0, (cap.size() < 4)}, 32'd1);
    wait_idle("merge", 600);
    e = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h28, 8'h33, 8'h2C, 8'h31, 8'h29, 8'h0D, 8'h0A};
    chk_frame("merge", e);

    // UART never raises busy: timeout per byte, 6 cycles between starts
    clear_cap();
    uart_stuck = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    wait_idle("stuck", 200);
    e = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    chk_frame("stuck", e);
    if (stamps.size() >= 4) begin
      check("stuck_gap01", stamps[1] - stamps[0], 32'd6);
      check("stuck_gap23", stamps[3] - stamps[2], 32'd6);
    end else begin
      check("stuck_stamps", stamps.size(), 32'd4);
    end
    uart_stuck = 1'b0;
    repeat (12) @(negedge clk);

    // Reset after the 2nd POS byte with ACK pending
    clear_cap();
    pulse(1'b0, 1'b0, 1'b1, 2'd2, 2'd1);
    n = 0;
    while (cap.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_two_bytes", cap.size(), 32'd2);
    pulse(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    check("rst_pre_busy", {31'b0, resp_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_start", {31'b0, tx_start}, 32'd0);
    check("rst_mid_data", {24'b0, tx_data}, 32'd0);
    check("rst_mid_busy", {31'b0, resp_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_more", cap.size(), 32'd2);
    check("rst_idle", {31'b0, resp_busy}, 32'd0);

    // Fresh request after reset works
    clear_cap();
    pulse(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    wait_idle("post_rst", 200);
    e = '{8'h45, 8'h52, 8'h0D, 8'h0A};
    chk_frame("post_rst", e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bluetooth_resp_tx.md
Name: bluetooth_resp_tx

Overview:
Builds ASCII response frames for the Bluetooth link and sends them byte by byte to the UART transmitter. It is the transmit counterpart of the command parser: it answers coordinate commands with ACK/ERR and reports the carriage position when a move completes. It sits between the motion/command logic and the UART TX core, and uses a start/busy byte handshake toward the UART TX core.

Parameters:
BUSY_WAIT_MAX, 4, max cycles to wait for tx_busy rising after tx_start before proceeding anyway (deadlock guard)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ack_req  input  1  one-cycle pulse: command accepted; send "OK\r\n"
err_req  input  1  one-cycle pulse: command rejected; send "ER\r\n"
pos_req  input  1  one-cycle pulse: move done; send "(x,y)\r\n"
pos_x  input  2  X coordinate, sampled when pos_req=1
pos_y  input  2  Y coordinate, sampled when pos_req=1
tx_busy  input  1  UART TX busy (high while a byte is shifting)
tx_start  output  1  one-cycle pulse: load tx_data into the UART
tx_data  output  8  byte to transmit; stable from tx_start until the next tx_start
resp_busy  output  1  high while any frame is pending or in flight

Behaviour:
- Reset: tx_start=0, tx_data=8'h00, resp_busy=0. All pending flags are cleared. The latched coordinates are 0. The FSM is in IDLE.
- Request capture runs every cycle, independent of FSM state:
  - A pulse on err_req, ack_req or pos_req sets the matching pending flag.
  - pos_req also latches pos_x and pos_y; a later pos_req overwrites them, so the newest position wins.
  - A repeated request of a type that is already pending merges with it: only one frame is sent.
  - A request arriving in the same cycle its frame is selected stays pending and produces one more frame.
- Frames:
  - ERR = 45 52 0D 0A
  - ACK = 4F 4B 0D 0A
  - POS = 28, 30+x, 2C, 30+y, 29, 0D, 0A
  - Coordinate bytes are 8'h30 | {6'b0, coord}.
- Selection, in IDLE when any flag is pending:
  - Priority is ERR > ACK > POS.
  - Clear the selected flag, load the frame type and the coordinate snapshot, set the byte index to 0, go to LOAD.
  - Frames never interleave: a higher-priority request waits for the current frame's last byte.
- FSM:
  - IDLE → LOAD when any flag is pending.
  - LOAD: if tx_busy=0, drive tx_data = the byte at the current index, pulse tx_start for 1 cycle, go to WAIT_HI. Otherwise hold in LOAD.
  - WAIT_HI: go to WAIT_LO when tx_busy=1, or when the counter reaches BUSY_WAIT_MAX cycles.
  - WAIT_LO: when tx_busy=0, go to LOAD with index+1. If that byte was the last one (index 3 for OK/ER, 6 for POS), go to IDLE instead.
- Latency: tx_start for the first byte comes 2 cycles after a request pulse that finds the FSM in IDLE with tx_busy=0 (capture cycle, then select cycle, then LOAD).
- resp_busy = (state≠IDLE) or any pending flag set. It goes high the cycle after the request.
- tx_data holds its last value between frames.
- Asynchronous reset mid-frame aborts the frame immediately: no further tx_start is issued and pending requests are lost.

Test Plan:
- ack_req pulse with tx_busy held low 0 cycles after start, high 10 cycles → bytes 4F,4B,0D,0A, four tx_start pulses, each one only after tx_busy falls; resp_busy returns to 0 after the last byte.
- pos_req with pos_x=2, pos_y=3 → bytes 28,32,2C,33,29,0D,0A.
- err_req, ack_req and pos_req (x=1, y=0) pulsed in the same cycle → order ER frame, OK frame, "(1,0)\r\n"; exactly 15 tx_start pulses.
- During an OK frame: pos_req (0,0), then pos_req (3,1) → a single POS frame "(3,1)\r\n" after OK finishes.
- tx_busy stuck at 0 (UART never asserts busy) → the FSM advances after BUSY_WAIT_MAX cycles per byte and the frame completes, with no hang.
- rst_n asserted after the 2nd byte of a POS frame with ack pending → all outputs at reset values immediately; no tx_start after release until a new request.
